ysyx_22050710_divider: RTL and testbench

Multi-cycle iterative radix-2 restoring divider. It is the responder to the EXU, which issues DIV/DIVU/REM/REMU and their W variants through a valid/ready request channel and takes results on a valid/ready response channel. It replaces single-cycle combinational "/" and "%" so the core meets timing. One request is in flight at a time.

---
 rtl/ysyx_22050710_divider_pkg.sv | 34 +++
 rtl/ysyx_22050710_div_signfix.sv | 15 +
 rtl/ysyx_22050710_divider.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_22050710_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_divider_pkg.sv
// Shared types, widths and helpers for the iterative restoring divider.
package ysyx_22050710_divider_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned HALF_W = 32;

    localparam logic [CNT_W-1:0] ITER_D = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] ITER_W = CNT_W'(HALF_W);

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Result payload handed back to the EXU
    typedef struct packed {
        logic [XLEN-1:0] quo;
        logic [XLEN-1:0] rem;
    } div_result_t;

    // Sign-extend a 32-bit value to XLEN
    function automatic logic [XLEN-1:0] sext32(input logic [HALF_W-1:0] v);
        return {{(XLEN - HALF_W){v[HALF_W-1]}}, v};
    endfunction

    // Zero-extend a 32-bit value to XLEN
    function automatic logic [XLEN-1:0] zext32(input logic [HALF_W-1:0] v);
        return {{(XLEN - HALF_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050710_div_signfix.sv
// Conditional two's-complement negate, used for operand abs and result fixup.
module ysyx_22050710_div_signfix
    import ysyx_22050710_divider_pkg::*;
(
    input  logic [XLEN-1:0] i_val,
    input  logic            i_neg,
    output logic [XLEN-1:0] o_val_c
);

    // Negate when requested, pass through otherwise
    always_comb begin
        o_val_c = i_neg ? (~i_val + XLEN'(1)) : i_val;
    end

endmodule

// File: rtl/ysyx_22050710_divider.sv
// Multi-cycle radix-2 restoring divider serving DIV/DIVU/REM/REMU and W variants.
module ysyx_22050710_divider
    import ysyx_22050710_divider_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_div_valid,
    output logic            o_div_ready,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_div_signed,
    input  logic            i_word,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  prem_q, prem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             word_q, word_d;
    div_result_t      res_q, res_d;
    logic             out_valid_q, out_valid_d;
    logic             div_ready_q, div_ready_d;

    logic [XLEN-1:0]  dnd_ext_c, dvs_ext_c;
    logic             dnd_neg_c, dvs_neg_c;
    logic [XLEN-1:0]  dnd_abs_c, dvs_abs_c;
    logic             div_zero_c, overflow_c, accept_c;
    logic [XLEN:0]    prem_sh_c, trial_c;
    logic [XLEN-1:0]  iter_prem_c, iter_quo_c;
    logic [XLEN-1:0]  quo_fix_c, rem_fix_c;
    logic [XLEN-1:0]  quo_fin_c, rem_fin_c;

    // Operand conditioning: width/sign extension and special-case detection
    always_comb begin
        if (i_word) begin
            dnd_ext_c = i_div_signed ? sext32(i_dividend[HALF_W-1:0]) : zext32(i_dividend[HALF_W-1:0]);
            dvs_ext_c = i_div_signed ? sext32(i_divisor[HALF_W-1:0])  : zext32(i_divisor[HALF_W-1:0]);
        end else begin
            dnd_ext_c = i_dividend;
            dvs_ext_c = i_divisor;
        end
        dnd_neg_c  = i_div_signed & dnd_ext_c[XLEN-1];
        dvs_neg_c  = i_div_signed & dvs_ext_c[XLEN-1];
        div_zero_c = (dvs_ext_c == '0);
        overflow_c = i_div_signed
                   & (dnd_ext_c == (i_word ? sext32(32'h8000_0000) : MIN_D))
                   & (dvs_ext_c == '1);
        accept_c   = (state_q == S_IDLE) & i_div_valid & ~i_flush;
    end

    ysyx_22050710_div_signfix u_abs_dnd (
        .i_val   (dnd_ext_c),
        .i_neg   (dnd_neg_c),
        .o_val_c (dnd_abs_c)
    );

    ysyx_22050710_div_signfix u_abs_dvs (
        .i_val   (dvs_ext_c),
        .i_neg   (dvs_neg_c),
        .o_val_c (dvs_abs_c)
    );

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        prem_sh_c   = {prem_q, quo_q[XLEN-1]};
        trial_c     = prem_sh_c - {1'b0, dvs_q};
        iter_prem_c = trial_c[XLEN] ? prem_sh_c[XLEN-1:0] : trial_c[XLEN-1:0];
        iter_quo_c  = {quo_q[XLEN-2:0], ~trial_c[XLEN]};
    end

    ysyx_22050710_div_signfix u_fix_quo (
        .i_val   (iter_quo_c),
        .i_neg   (neg_quo_q),
        .o_val_c (quo_fix_c)
    );

    ysyx_22050710_div_signfix u_fix_rem (
        .i_val   (iter_prem_c),
        .i_neg   (neg_rem_q),
        .o_val_c (rem_fix_c)
    );

    // W results are always sign-extended from bit 31, even for unsigned ops
    always_comb begin
        quo_fin_c = word_q ? sext32(quo_fix_c[HALF_W-1:0]) : quo_fix_c;
        rem_fin_c = word_q ? sext32(rem_fix_c[HALF_W-1:0]) : rem_fix_c;
    end

    // Next-state, datapath and output-register update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        word_d    = word_q;
        res_d     = res_q;

        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        word_d    = i_word;
                        neg_quo_d = dnd_neg_c ^ dvs_neg_c;
                        neg_rem_d = dnd_neg_c;
                        if (div_zero_c) begin
                            res_d.quo = '1;
                            res_d.rem = i_word ? sext32(i_dividend[HALF_W-1:0]) : i_dividend;
                            state_d   = S_DONE;
                        end else if (overflow_c) begin
                            res_d.quo = dnd_ext_c;
                            res_d.rem = '0;
                            state_d   = S_DONE;
                        end else begin
                            // W magnitudes start at the top so their bits shift out first
                            prem_d  = '0;
                            quo_d   = i_word ? {dnd_abs_c[HALF_W-1:0], {HALF_W{1'b0}}} : dnd_abs_c;
                            dvs_d   = dvs_abs_c;
                            cnt_d   = i_word ? ITER_W : ITER_D;
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    prem_d = iter_prem_c;
                    quo_d  = iter_quo_c;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        res_d.quo = quo_fin_c;
                        res_d.rem = rem_fin_c;
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        out_valid_d = (state_d == S_DONE);
        div_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            word_q      <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            div_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            word_q      <= word_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            div_ready_q <= div_ready_d;
        end
    end

    assign o_div_ready = div_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_quotient  = res_q.quo;
    assign o_remainder = res_q.rem;

endmodule

// File: tb/tb_ysyx_22050710_divider.sv
// Self-checking bench for the iterative divider against an arithmetic reference model.
module tb_ysyx_22050710_divider;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush;
    logic        i_div_valid;
    logic        o_div_ready;
    logic [63:0] i_dividend;
    logic [63:0] i_divisor;
    logic        i_div_signed;
    logic        i_word;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [63:0] o_quotient;
    logic [63:0] o_remainder;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22050710_divider dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_div_valid  (i_div_valid),
        .o_div_ready  (o_div_ready),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .i_div_signed (i_div_signed),
        .i_word       (i_word),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // RISC-V M-extension semantics computed with plain arithmetic
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                    input bit sgn, input bit wrd,
                                    output logic [63:0] q, output logic [63:0] r,
                                    output int lat);
        logic [31:0] a32, b32, q32, r32;
        lat = wrd ? 33 : 65;
        if (wrd) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; lat = 1;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; lat = 1;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a; lat = 1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 64'd0; lat = 1;
            end else if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Issue one op, check latency, hold result for `stall` cycles, then drain it
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input bit sgn, input bit wrd, input int stall);
        logic [63:0] eq, er;
        int exp_lat;
        int lat;
        ref_div(a, b, sgn, wrd, eq, er, exp_lat);
        lat = 0;
        while (!o_div_ready && lat < 200) begin
            step();
            lat++;
        end
        check_eq({tag, " ready_idle"}, 64'(o_div_ready), 64'd1);
        i_dividend   = a;
        i_divisor    = b;
        i_div_signed = sgn;
        i_word       = wrd;
        i_div_valid  = 1'b1;
        step();
        i_div_valid  = 1'b0;
        lat = 1;
        while (!o_out_valid && lat < 200) begin
            step();
            lat++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " ready_done"}, 64'(o_div_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            step();
        end
        check_eq({tag, " valid_hold"}, 64'(o_out_valid), 64'd1);
        check_eq({tag, " quotient"}, o_quotient, eq);
        check_eq({tag, " remainder"}, o_remainder, er);
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
        check_eq({tag, " valid_drop"}, 64'(o_out_valid), 64'd0);
        check_eq({tag, " ready_back"}, 64'(o_div_ready), 64'd1);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return 64'h8000_0000_0000_0000;
            2: return '1;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'h1234_5678_FFFF_FFFF;
            5: return 64'($urandom_range(0, 15));
            6: return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int lat;
        i_rst        = 1'b1;
        i_flush      = 1'b0;
        i_div_valid  = 1'b0;
        i_dividend   = '0;
        i_divisor    = '0;
        i_div_signed = 1'b0;
        i_word       = 1'b0;
        i_out_ready  = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        check_eq("rst ready", 64'(o_div_ready), 64'd1);
        check_eq("rst valid", 64'(o_out_valid), 64'd0);
        check_eq("rst quo", o_quotient, 64'd0);
        check_eq("rst rem", o_remainder, 64'd0);

        run_op("div_neg7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 0);
        run_op("divu_by0", 64'h1234, 64'd0, 1'b0, 1'b0, 0);
        run_op("div_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 0);
        run_op("divw_neg7_3", 64'hDEAD_BEEF_FFFF_FFF9, 64'd3, 1'b1, 1'b1, 0);
        run_op("divuw", 64'h0000_0000_FFFF_FFFE, 64'd2, 1'b0, 1'b1, 0);
        run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 0);
        run_op("divuw_by0", 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 0);
        run_op("stall3", 64'd100, 64'd7, 1'b0, 1'b0, 3);

        // Flush in the tenth BUSY cycle discards the op
        i_dividend   = 64'd1000;
        i_divisor    = 64'd3;
        i_div_signed = 1'b0;
        i_word       = 1'b0;
        i_div_valid  = 1'b1;
        step();
        i_div_valid  = 1'b0;
        repeat (9) step();
        check_eq("busy ready", 64'(o_div_ready), 64'd0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check_eq("flush ready", 64'(o_div_ready), 64'd1);
        check_eq("flush valid", 64'(o_out_valid), 64'd0);
        lat = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (o_out_valid) lat++;
        end
        check_eq("flush no_result", 64'(lat), 64'd0);

        // Flush alongside a request blocks acceptance
        i_div_valid = 1'b1;
        i_flush     = 1'b1;
        step();
        i_div_valid = 1'b0;
        i_flush     = 1'b0;
        step();
        check_eq("flush_req ready", 64'(o_div_ready), 64'd1);
        run_op("after_flush", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 1);

        // Reset in the middle of BUSY restores every output
        i_dividend  = 64'd55;
        i_divisor   = 64'd5;
        i_div_valid = 1'b1;
        step();
        i_div_valid = 1'b0;
        repeat (5) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_eq("midrst ready", 64'(o_div_ready), 64'd1);
        check_eq("midrst valid", 64'(o_out_valid), 64'd0);
        check_eq("midrst quo", o_quotient, 64'd0);
        check_eq("midrst rem", o_remainder, 64'd0);

        for (int k = 0; k < 600; k++) begin
            run_op("rand", pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
